// File: rtl/axi_lite_cmd_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI-Lite master.
// It latches the winning command, issues it, waits for completion or a timeout, and routes the response back.
module axi_lite_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic        req0_write,
  input  logic        req1_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req0_wdata,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req0_wstrb,
  input  logic [3:0]  req1_wstrb,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        start_read,
  output logic        start_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_done,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_resp,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_flag
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic        r_ptr;
  logic [15:0] r_cnt;
  logic        r_grant_id;
  logic        r_timeout_flag;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_any_valid;
  logic w_win_id;
  logic w_idle;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_win_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      w_win_id = r_ptr;
    end else if (req1_valid) begin
      w_win_id = 1'b1;
    end
  end

  assign w_idle = (r_state == S_IDLE) && !areset;

  assign req0_ready  = w_idle && w_any_valid && !w_win_id;
  assign req1_ready  = w_idle && w_any_valid &&  w_win_id;
  assign start_write = (r_state == S_ISSUE) && !areset &&  r_write;
  assign start_read  = (r_state == S_ISSUE) && !areset && !r_write;
  assign rsp0_valid  = (r_state == S_RESP) && !areset && !r_grant_id;
  assign rsp1_valid  = (r_state == S_RESP) && !areset &&  r_grant_id;

  assign busy         = (r_state != S_IDLE);
  assign grant_id     = r_grant_id;
  assign timeout_flag = r_timeout_flag;
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;
  assign m_addr       = r_addr;
  assign m_wdata      = r_wdata;
  assign m_wstrb      = r_wstrb;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state        <= S_IDLE;
      r_ptr          <= 1'b0;
      r_cnt          <= '0;
      r_grant_id     <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_write        <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      r_rdata        <= '0;
      r_err          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_grant_id <= w_win_id;
            r_write    <= w_win_id ? req1_write : req0_write;
            r_addr     <= w_win_id ? req1_addr  : req0_addr;
            r_wdata    <= w_win_id ? req1_wdata : req0_wdata;
            r_wstrb    <= w_win_id ? req1_wstrb : req0_wstrb;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion wins over a timeout expiring in the same cycle.
          if (m_done) begin
            r_rdata <= r_write ? '0 : m_rdata;
            r_err   <= (m_resp != 2'b00);
            r_state <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rdata        <= '0;
            r_err          <= 1'b1;
            r_timeout_flag <= 1'b1;
            r_state        <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          r_ptr   <= ~r_grant_id;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_lite_cmd_arbiter.md
AXI_LITE_CMD_ARBITER -- requirements
Module: axi_lite_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum WAIT-state cycles before a transaction is aborted; legal range 2..65535.
REQ-002 aclk  input  1  single clock; all logic rising-edge.
REQ-003 areset  input  1  synchronous, active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has a command pending.
REQ-005 req0_write, req1_write  input  1 each  1 = write, 0 = read.
REQ-006 req0_addr, req1_addr  input  32 each  command address.
REQ-007 req0_wdata, req1_wdata  input  32 each  write data.
REQ-008 req0_wstrb, req1_wstrb  input  4 each  write byte strobes.
REQ-009 req0_ready, req1_ready  output  1 each  one-cycle accept pulse to requester N.
REQ-010 rsp0_valid, rsp1_valid  output  1 each  one-cycle completion pulse to requester N.
REQ-011 rsp_rdata  output  32  read data for the current response; 0 on writes and timeouts.
REQ-012 rsp_err  output  1  response error; qualified by rspN_valid.
REQ-013 start_read, start_write  output  1 each  one-cycle command pulses to the AXI-Lite master.
REQ-014 m_addr, m_wdata  output  32 each  command address/data to the master.
REQ-015 m_wstrb  output  4  strobes to the master.
REQ-016 m_done  input  1  master completion pulse (B or R handshake done).
REQ-017 m_rdata  input  32  master read data, valid with m_done.
REQ-018 m_resp  input  2  BRESP/RRESP, valid with m_done.
REQ-019 busy, grant_id, timeout_flag  output  1 each  FSM not IDLE; current/last owner; sticky timeout indicator.

Function
REQ-020 The FSM SHALL use states IDLE, ISSUE, WAIT, RESP; encoded value of state[1:0] SHALL be 0, 1, 2, 3 respectively.
REQ-021 In IDLE with exactly one reqN_valid high, that requester SHALL win regardless of priority.
REQ-022 In IDLE with both valid, the requester indicated by the 1-bit round-robin pointer (reset 0) SHALL win.
REQ-023 On a win, the winner's ready SHALL pulse high that same cycle; write, addr, wdata, wstrb SHALL be latched; grant_id SHALL be set to the winner; next state SHALL be ISSUE.
REQ-024 The loser's ready SHALL stay low; ready SHALL never be high outside IDLE.
REQ-025 In ISSUE, exactly one of start_write/start_read SHALL pulse for one cycle per the latched write bit; next state SHALL be WAIT with the timeout counter cleared.
REQ-026 m_addr, m_wdata, m_wstrb SHALL drive latched values from ISSUE through RESP, unchanged.
REQ-027 m_done SHALL be sampled only in WAIT; pulses in any other state SHALL be ignored.
REQ-028 In WAIT with m_done high, the arbiter SHALL capture rsp_rdata = m_rdata for reads and 0 for writes, set rsp_err = (m_resp != 0), and go to RESP.
REQ-029 In WAIT without m_done, the counter SHALL increment; when it equals TIMEOUT_CYCLES-1, the arbiter SHALL set rsp_err=1, rsp_rdata=0, timeout_flag=1 and go to RESP.
REQ-030 m_done arriving on the timeout cycle SHALL take precedence over the timeout.
REQ-031 In RESP, rspN_valid SHALL pulse one cycle for the owner only; the pointer SHALL become the non-owner; next state SHALL be IDLE.
REQ-032 Latency: accept at cycle T, start pulse at T+1, m_done at T+1+k (k>=1) gives rsp pulse at T+2+k; next accept no earlier than T+3+k.
REQ-033 timeout_flag SHALL remain set until reset.
REQ-034 busy SHALL be high in ISSUE, WAIT, and RESP.

Reset
REQ-035 While areset is high at a clock edge: state=IDLE, pointer=0, counter=0, grant_id=0, timeout_flag=0, rsp_rdata=0, rsp_err=0, m_addr/m_wdata/m_wstrb=0, and all ready/valid/start outputs=0.
REQ-036 Reset asserted mid-transaction SHALL abort without issuing a response; a later m_done SHALL be ignored.

Verification
REQ-037 Single read: req0 addr=0x10 -> start_read at T+1; m_done at T+3 with m_rdata=0xDEADBEEF, m_resp=0 -> rsp0_valid at T+4, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-038 Contention: req0 and req1 held valid from reset -> grants alternate 0,1,0,1 across four transactions; each requester receives exactly two responses.
REQ-039 Write error: req1 write addr=0x20 wdata=0x55 wstrb=0xF, m_resp=2 -> start_write once; m_wdata=0x55; rsp1_valid with rsp_err=1 and rsp_rdata=0.
REQ-040 Timeout: TIMEOUT_CYCLES=4, no m_done -> rsp_err=1 and timeout_flag=1 after 4 WAIT cycles; a late m_done in IDLE is ignored; the next request proceeds normally.
REQ-041 Reset mid-WAIT: areset for one cycle -> all outputs 0, no rsp pulse; pointer=0, so req0 wins the next contention.
REQ-042 Boundary: m_done on the final timeout cycle -> rsp_err reflects m_resp and timeout_flag remains 0.
